// File: rtl/target_weight_sync.sv
// target_weight_sync: copies every main-network weight into target_net,
// one layer after another, streaming through the weight-load port.
module target_weight_sync #(
   parameter int DATA_WIDTH                    = 32,
   parameter int LAYER_WIDTH                   = 2,
   parameter int NUMBER_OF_INPUT_NODE          = 2,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
   parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
   parameter int NUMBER_OF_OUTPUT_NODE         = 3,
   parameter int WEIGHT_COUNTER_WIDTH          = 11
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_start,
   input  logic                            i_pause,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_rd_en,
   output logic [LAYER_WIDTH-1:0]          o_rd_layer,
   output logic [WEIGHT_COUNTER_WIDTH-1:0] o_rd_addr,
   input  logic [DATA_WIDTH-1:0]           i_rd_data,
   output logic                            o_weight_valid,
   output logic [LAYER_WIDTH-1:0]          o_weight_layer,
   output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
   output logic [DATA_WIDTH-1:0]           o_weight
);

   localparam int IN  = NUMBER_OF_INPUT_NODE;
   localparam int H1  = NUMBER_OF_HIDDEN_NODE_LAYER_1;
   localparam int H2  = NUMBER_OF_HIDDEN_NODE_LAYER_2;
   localparam int OUT = NUMBER_OF_OUTPUT_NODE;
   localparam int AW  = WEIGHT_COUNTER_WIDTH;
   localparam int LW  = LAYER_WIDTH;

   // Each layer holds node-major weights with one trailing bias per node.
   localparam logic [AW-1:0] L1_LAST = AW'(H1 * (IN + 1) - 1);
   localparam logic [AW-1:0] L2_LAST = AW'(H2 * (H1 + 1) - 1);
   localparam logic [AW-1:0] LO_LAST = AW'(OUT * (H2 + 1) - 1);

   localparam logic [LW-1:0] CODE_L1 = LW'(1);
   localparam logic [LW-1:0] CODE_L2 = LW'(2);
   localparam logic [LW-1:0] CODE_LO = LW'(3);

   typedef enum logic [2:0] {
      IDLE, RD_L1, RD_L2, RD_OUT, DRAIN, DONE
   } state_t;

   state_t          state;
   state_t          next_rd;
   logic [AW-1:0]   addr;
   logic [AW-1:0]   last_addr;
   logic [LW-1:0]   rd_layer;
   logic            in_rd;
   logic            rd_en;
   logic [DATA_WIDTH-1:0] held_weight;

   // Per-state layer code, last address and successor of the read phase.
   always_comb begin
      rd_layer  = '0;
      last_addr = '0;
      next_rd   = IDLE;
      in_rd     = 1'b0;
      unique case (state)
         RD_L1: begin
            rd_layer  = CODE_L1;
            last_addr = L1_LAST;
            next_rd   = RD_L2;
            in_rd     = 1'b1;
         end
         RD_L2: begin
            rd_layer  = CODE_L2;
            last_addr = L2_LAST;
            next_rd   = RD_OUT;
            in_rd     = 1'b1;
         end
         RD_OUT: begin
            rd_layer  = CODE_LO;
            last_addr = LO_LAST;
            next_rd   = DRAIN;
            in_rd     = 1'b1;
         end
         default: begin
            rd_layer  = '0;
            last_addr = '0;
            next_rd   = IDLE;
            in_rd     = 1'b0;
         end
      endcase
      rd_en = in_rd && !i_pause;
   end

   // Sequencer: walk every layer address, then drain and signal done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_start) begin
                  state <= RD_L1;
                  addr  <= '0;
               end
            end
            RD_L1, RD_L2, RD_OUT: begin
               if (rd_en) begin
                  if (addr == last_addr) begin
                     addr  <= '0;
                     state <= next_rd;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            DRAIN:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Align layer/addr tags with the RAM's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_weight_valid <= 1'b0;
         o_weight_layer <= '0;
         o_weight_addr  <= '0;
         held_weight    <= '0;
      end else begin
         o_weight_valid <= rd_en;
         if (rd_en) begin
            o_weight_layer <= rd_layer;
            o_weight_addr  <= addr;
         end
         if (o_weight_valid) begin
            held_weight <= i_rd_data;
         end
      end
   end

   // RAM data is forwarded on a valid beat and held otherwise.
   always_comb begin
      o_weight = o_weight_valid ? i_rd_data : held_weight;
   end

   assign o_busy     = (state != IDLE);
   assign o_done     = (state == DONE);
   assign o_rd_en    = rd_en;
   assign o_rd_layer = rd_layer;
   assign o_rd_addr  = addr;

endmodule

// File: tb/tb_target_weight_sync.sv
// Bench for target_weight_sync: randomized RAM contents, expected beat
// list built from the layer sizes, directed copy/pause/start/reset steps.
module tb_target_weight_sync;

   localparam int DW    = 32;
   localparam int LW    = 2;
   localparam int AW    = 11;
   localparam int IN    = 2;
   localparam int H1    = 32;
   localparam int H2    = 32;
   localparam int OUT   = 3;
   localparam int SZ1   = H1 * (IN + 1);
   localparam int SZ2   = H2 * (H1 + 1);
   localparam int SZO   = OUT * (H2 + 1);
   localparam int TOTAL = SZ1 + SZ2 + SZO;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic          i_pause;
   logic          o_busy;
   logic          o_done;
   logic          o_rd_en;
   logic [LW-1:0] o_rd_layer;
   logic [AW-1:0] o_rd_addr;
   logic [DW-1:0] i_rd_data;
   logic          o_weight_valid;
   logic [LW-1:0] o_weight_layer;
   logic [AW-1:0] o_weight_addr;
   logic [DW-1:0] o_weight;

   int tests = 0;
   int fails = 0;
   logic [31:0] key;
   logic [12:0] expq[$];
   logic [44:0] last_exp;

   target_weight_sync dut (
      .clk            (clk),
      .rst            (rst),
      .i_start        (i_start),
      .i_pause        (i_pause),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_rd_en        (o_rd_en),
      .o_rd_layer     (o_rd_layer),
      .o_rd_addr      (o_rd_addr),
      .i_rd_data      (i_rd_data),
      .o_weight_valid (o_weight_valid),
      .o_weight_layer (o_weight_layer),
      .o_weight_addr  (o_weight_addr),
      .o_weight       (o_weight)
   );

   always #5 clk = ~clk;

   // Main RAM: one-cycle read latency, garbage when not read.
   always @(posedge clk) begin
      if (o_rd_en)
         i_rd_data <= key ^ {o_rd_layer, 19'd0, o_rd_addr};
      else
         i_rd_data <= $urandom;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [44:0] beat_of(input logic [12:0] la);
      logic [31:0] w;
      w = key ^ {la[12:11], 19'd0, la[10:0]};
      return {la, w};
   endfunction

   // One copy. pl: pause length at L2 addr 501; pokes: stray starts;
   // rst_at: cycle of a mid-copy reset; chain: start again in first IDLE.
   task automatic copy(input bit chained, input int pl, input bit pokes,
                       input int rst_at, input bit chain);
      int ps;
      int d;
      int beats;
      int ecyc;
      logic [12:0] ea;
      logic [44:0] e;
      ps = 1 + SZ1 + 501;
      d  = TOTAL + 2 + pl;
      if (!chained) key = $urandom;
      expq = {};
      for (int a = 0; a < SZ1; a++) expq.push_back({2'b01, 11'(a)});
      for (int a = 0; a < SZ2; a++) expq.push_back({2'b10, 11'(a)});
      for (int a = 0; a < SZO; a++) expq.push_back({2'b11, 11'(a)});
      if (!chained) i_start = 1'b1;
      tick();
      i_start = 1'b0;
      beats = 0;
      for (int c = 1; c <= d + 1; c++) begin
         i_pause = (pl > 0) && (c >= ps) && (c < ps + pl);
         i_start = (pokes && (c == 100 || c == d)) ||
                   (chain && c == d + 1);
         rst     = (rst_at > 0) && (c == rst_at);
         #1;
         if (rst_at > 0 && c > rst_at) begin
            if (c == rst_at + 1)
               chk("rst_outs",
                   {o_busy, o_done, o_rd_en, o_rd_layer, o_rd_addr,
                    o_weight_valid, o_weight_layer, o_weight_addr,
                    o_weight}, 64'd0);
            chk("rst_quiet", {o_busy, o_done, o_weight_valid}, 64'd0);
            last_exp = '0;
            if (c == rst_at + 20) break;
         end else begin
            chk("busy", o_busy, c <= d);
            chk("done", o_done, c == d);
            if (o_weight_valid) begin
               beats++;
               if (expq.size() == 0) begin
                  chk("extra_beat", beats, TOTAL);
               end else begin
                  ea = expq.pop_front();
                  e  = beat_of(ea);
                  chk("beat", {o_weight_layer, o_weight_addr, o_weight}, e);
                  ecyc = beats + 1 + ((beats - 1 > SZ1 + 500) ? pl : 0);
                  chk("beat_cycle", c, ecyc);
                  last_exp = e;
               end
            end else begin
               chk("hold", {o_weight_layer, o_weight_addr, o_weight},
                   last_exp);
            end
            if (c == d + 1) begin
               chk("beat_count", beats, TOTAL);
               chk("queue_left", expq.size(), 0);
            end
         end
         if (c <= d) tick();
      end
      i_pause = 1'b0;
      rst     = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      i_start  = 1'b0;
      i_pause  = 1'b0;
      key      = '0;
      last_exp = '0;
      tick();
      tick();
      #1;
      chk("reset_outs",
          {o_busy, o_done, o_rd_en, o_rd_layer, o_rd_addr,
           o_weight_valid, o_weight_layer, o_weight_addr, o_weight},
          64'd0);
      rst = 1'b0;
      // idle pause has no effect
      i_pause = 1'b1;
      tick();
      tick();
      #1;
      chk("idle_pause", {o_busy, o_done, o_weight_valid}, 64'd0);
      i_pause = 1'b0;
      tick();
      copy(1'b0, 0, 1'b0, 0, 1'b0);
      copy(1'b0, 7, 1'b0, 0, 1'b0);
      copy(1'b0, 0, 1'b1, 0, 1'b1);
      copy(1'b1, 0, 1'b0, 0, 1'b0);
      copy(1'b0, 0, 1'b0, 600, 1'b0);
      copy(1'b0, 0, 1'b0, 0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
